// File: rtl/out_bank_ring_ctrl.sv
// Output DMA descriptor generator rotating packets through a ring of memory banks.
// Optional OBANK_ERR_CAPTURE_EN: sticky first-error capture into ERR; errored completions keep DONE_WRITE low.
module out_bank_ring_ctrl #(
  parameter int unsigned N_BANKS        = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_LEN_WIDTH  = 32,
  parameter int unsigned AXI_TAG_WIDTH  = 8,
  parameter int unsigned REG_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0] reg_wr_data,
  input  logic                      reg_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
  output logic [AXI_DATA_WIDTH-1:0] reg_rd_data,
  input  logic                      o_valid,
  input  logic                      o_ready,
  input  logic                      o_last,
  input  logic [AXI_LEN_WIDTH-1:0]  o_bpt,
  input  logic                      os_valid,
  input  logic [3:0]                os_error,
  input  logic [AXI_TAG_WIDTH-1:0]  os_tag,
  output logic [AXI_ADDR_WIDTH-1:0] m_od_addr,
  output logic [AXI_LEN_WIDTH-1:0]  m_od_len,
  output logic [AXI_TAG_WIDTH-1:0]  m_od_tag,
  output logic                      m_od_valid,
  input  logic                      m_od_ready
);

  localparam int unsigned IDX_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int unsigned CNT_W = $clog2(N_BANKS + 1);
  localparam int unsigned OUT_W = 8;

  logic                      r_start;
  logic [CNT_W-1:0]          r_n_active;
  logic [IDX_W-1:0]          r_cur_idx;
  logic                      r_got_last;
  logic                      r_o_done;
  logic [OUT_W-1:0]          r_outstanding;
  logic [N_BANKS-1:0]        r_done_read;
  logic [N_BANKS-1:0]        r_done_write;
  logic [AXI_ADDR_WIDTH-1:0] r_base  [N_BANKS];
  logic [AXI_LEN_WIDTH-1:0]  r_bytes [N_BANKS];
  logic                      r_od_valid;
  logic [AXI_ADDR_WIDTH-1:0] r_od_addr;
  logic [AXI_LEN_WIDTH-1:0]  r_od_len;
  logic [AXI_TAG_WIDTH-1:0]  r_od_tag;
  logic [AXI_DATA_WIDTH-1:0] r_rd_data;

  logic                      w_start;
  logic [CNT_W-1:0]          w_last_idx;
  logic [IDX_W-1:0]          w_nxt;
  logic                      w_issue;
  logic                      w_beat_last;
  logic                      w_tag_ok;
  logic                      w_cpl;
  logic [IDX_W-1:0]          w_cpl_idx;
  logic                      w_hs;
  logic                      w_dw_set;
  logic [CNT_W-1:0]          w_nact_wr;
  logic [AXI_DATA_WIDTH-1:0] w_rd_data;
  logic [AXI_DATA_WIDTH-1:0] w_err_rd;

  assign w_start     = reg_wr_en && (reg_wr_addr == '0) && reg_wr_data[0];
  assign w_last_idx  = r_n_active - CNT_W'(1);
  assign w_nxt       = (CNT_W'(r_cur_idx) >= w_last_idx) ? '0 : r_cur_idx + IDX_W'(1);
  assign w_issue     = o_valid && r_got_last && r_done_read[w_nxt] && !r_od_valid && !w_start;
  assign w_beat_last = o_valid && o_ready && o_last;
  assign w_tag_ok    = 32'(os_tag) < 32'(r_n_active);
  assign w_cpl       = os_valid && w_tag_ok;
  assign w_cpl_idx   = IDX_W'(os_tag);
  assign w_hs        = r_od_valid && m_od_ready;

`ifdef OBANK_ERR_CAPTURE_EN
  logic [AXI_DATA_WIDTH-1:0] r_err;
  logic                      w_err_evt;
  logic [31:0]               w_err_val;

  assign w_dw_set  = (os_error == 4'd0);
  assign w_err_evt = os_valid && ((os_error != 4'd0) || !w_tag_ok);
  assign w_err_val = {1'b1, 15'd0, 8'(os_tag), 4'd0, os_error};
  assign w_err_rd  = r_err;

  // First error is sticky until the next START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else if (w_start) begin
      r_err <= '0;
    end else if (w_err_evt && (r_err == '0)) begin
      r_err <= AXI_DATA_WIDTH'(w_err_val);
    end
  end
`else
  logic w_unused;

  assign w_dw_set = 1'b1;
  assign w_err_rd = '0;
  assign w_unused = ^os_error;
`endif

  // N_ACTIVE writes are clamped into the legal ring size.
  always_comb begin
    w_nact_wr = CNT_W'(N_BANKS);
    if (reg_wr_data < AXI_DATA_WIDTH'(2)) begin
      w_nact_wr = CNT_W'(2);
    end else if (reg_wr_data <= AXI_DATA_WIDTH'(N_BANKS)) begin
      w_nact_wr = CNT_W'(reg_wr_data);
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (reg_rd_addr)
      REG_ADDR_WIDTH'(0): w_rd_data = AXI_DATA_WIDTH'(r_start);
      REG_ADDR_WIDTH'(1): w_rd_data = AXI_DATA_WIDTH'(r_n_active);
      REG_ADDR_WIDTH'(2): w_rd_data = AXI_DATA_WIDTH'(r_o_done);
      REG_ADDR_WIDTH'(3): w_rd_data = w_err_rd;
      REG_ADDR_WIDTH'(4): w_rd_data = AXI_DATA_WIDTH'({r_outstanding, 8'(r_cur_idx)});
      default:            w_rd_data = '0;
    endcase
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      if (reg_rd_addr == REG_ADDR_WIDTH'(8 + 4 * b)) w_rd_data = AXI_DATA_WIDTH'(r_base[b]);
      if (reg_rd_addr == REG_ADDR_WIDTH'(9 + 4 * b)) w_rd_data = AXI_DATA_WIDTH'(r_done_read[b]);
      if (reg_rd_addr == REG_ADDR_WIDTH'(10 + 4 * b)) w_rd_data = AXI_DATA_WIDTH'(r_done_write[b]);
      if (reg_rd_addr == REG_ADDR_WIDTH'(11 + 4 * b)) w_rd_data = AXI_DATA_WIDTH'(r_bytes[b]);
    end
  end

  // Software writes come first so same-cycle hardware updates override them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start       <= 1'b0;
      r_n_active    <= CNT_W'(2);
      r_cur_idx     <= IDX_W'(N_BANKS - 1);
      r_got_last    <= 1'b1;
      r_o_done      <= 1'b0;
      r_outstanding <= '0;
      r_done_read   <= '1;
      r_done_write  <= '0;
      for (int unsigned b = 0; b < N_BANKS; b++) begin
        r_base[b]  <= '0;
        r_bytes[b] <= '0;
      end
    end else begin
      r_start <= w_start;
      if (reg_wr_en && (reg_wr_addr == REG_ADDR_WIDTH'(1))) r_n_active <= w_nact_wr;
      for (int unsigned b = 0; b < N_BANKS; b++) begin
        if (reg_wr_en && (reg_wr_addr == REG_ADDR_WIDTH'(8 + 4 * b))) begin
          r_base[b] <= AXI_ADDR_WIDTH'(reg_wr_data);
        end
        if (reg_wr_en && (reg_wr_addr == REG_ADDR_WIDTH'(9 + 4 * b))) begin
          r_done_read[b] <= reg_wr_data[0];
        end
      end

      if (w_start) begin
        r_cur_idx     <= IDX_W'(w_last_idx);
        r_done_read   <= '1;
        r_done_write  <= '0;
        r_outstanding <= '0;
        r_o_done      <= 1'b0;
        r_got_last    <= 1'b1;
      end else begin
        if (w_issue) begin
          r_done_read[w_nxt]  <= 1'b0;
          r_done_write[w_nxt] <= 1'b0;
          r_bytes[w_nxt]      <= o_bpt;
          r_cur_idx           <= w_nxt;
          r_got_last          <= 1'b0;
        end
        if (w_beat_last) r_got_last <= 1'b1;
        if (w_cpl && w_dw_set) r_done_write[w_cpl_idx] <= 1'b1;

        unique case ({w_hs, w_cpl})
          2'b10: if (r_outstanding != '1) r_outstanding <= r_outstanding + OUT_W'(1);
          2'b01: if (r_outstanding != '0) r_outstanding <= r_outstanding - OUT_W'(1);
          default: ;
        endcase

        if (o_valid) begin
          r_o_done <= 1'b0;
        end else if (r_got_last && (r_outstanding == '0) && !r_od_valid) begin
          r_o_done <= 1'b1;
        end
      end
    end
  end

  // Descriptor holding register; fields stay stable until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_od_valid <= 1'b0;
      r_od_addr  <= '0;
      r_od_len   <= '0;
      r_od_tag   <= '0;
    end else if (w_issue) begin
      r_od_valid <= 1'b1;
      r_od_addr  <= r_base[w_nxt];
      r_od_len   <= o_bpt;
      r_od_tag   <= AXI_TAG_WIDTH'(w_nxt);
    end else if (m_od_ready) begin
      r_od_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (reg_rd_en) begin
      r_rd_data <= w_rd_data;
    end
  end

  assign reg_rd_data = r_rd_data;
  assign m_od_valid  = r_od_valid;
  assign m_od_addr   = r_od_addr;
  assign m_od_len    = r_od_len;
  assign m_od_tag    = r_od_tag;

endmodule

// File: tb/tb_out_bank_ring_ctrl.sv
// Self-checking bench for out_bank_ring_ctrl: directed scenarios plus a randomized ring walk.
module tb_out_bank_ring_ctrl;
  localparam int unsigned NB = 4;

`ifdef OBANK_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_wr_en = 1'b0;
  logic [7:0]  reg_wr_addr = '0;
  logic [31:0] reg_wr_data = '0;
  logic        reg_rd_en = 1'b0;
  logic [7:0]  reg_rd_addr = '0;
  logic [31:0] reg_rd_data;
  logic        o_valid = 1'b0, o_ready = 1'b0, o_last = 1'b0;
  logic [31:0] o_bpt = '0;
  logic        os_valid = 1'b0;
  logic [3:0]  os_error = '0;
  logic [7:0]  os_tag = '0;
  logic [31:0] m_od_addr, m_od_len;
  logic [7:0]  m_od_tag;
  logic        m_od_valid;
  logic        m_od_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  out_bank_ring_ctrl #(
    .N_BANKS(NB), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
    .AXI_LEN_WIDTH(32), .AXI_TAG_WIDTH(8), .REG_ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last), .o_bpt(o_bpt),
    .os_valid(os_valid), .os_error(os_error), .os_tag(os_tag),
    .m_od_addr(m_od_addr), .m_od_len(m_od_len), .m_od_tag(m_od_tag),
    .m_od_valid(m_od_valid), .m_od_ready(m_od_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input int a, input logic [31:0] d);
    reg_wr_en = 1'b1; reg_wr_addr = 8'(a); reg_wr_data = d;
    tick();
    reg_wr_en = 1'b0;
  endtask

  task automatic reg_rd(input int a, output logic [31:0] d);
    reg_rd_en = 1'b1; reg_rd_addr = 8'(a);
    tick();
    reg_rd_en = 1'b0;
    d = reg_rd_data;
  endtask

  task automatic start_ring();
    reg_wr(0, 32'd1);
    tick();
  endtask

  task automatic wait_desc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (m_od_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic finish_beat();
    o_ready = 1'b1; o_last = 1'b1;
    tick();
    o_valid = 1'b0; o_ready = 1'b0; o_last = 1'b0;
  endtask

  task automatic complete(input int tag, input int err);
    os_valid = 1'b1; os_tag = 8'(tag); os_error = 4'(err);
    tick();
    os_valid = 1'b0; os_tag = '0; os_error = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (m_od_valid !== 1'b0 || m_od_addr !== 32'd0 || m_od_len !== 32'd0 || m_od_tag !== 8'd0 || reg_rd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b addr=%h len=%h tag=%h rd=%h, expected all zero", m_od_valid, m_od_addr, m_od_len, m_od_tag, reg_rd_data);
    end
    reg_rd(1, d); checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL reset_n_active: got %h expected 2", d); end
    reg_rd(4, d); checks++;
    if (d !== 32'(NB - 1)) begin errors++; $display("FAIL reset_status: got %h expected %h", d, NB - 1); end
    reg_rd(9, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL reset_done_read0: got %h expected 1", d); end
    reg_rd(5, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
  endtask

  task automatic test_ring();
    logic [31:0] d;
    bit ok, seen;
    reg_wr(1, 32'd3);
    for (int b = 0; b < 3; b++) reg_wr(8 + 4 * b, 32'h1000 * (b + 1));
    start_ring();
    for (int p = 0; p < 3; p++) begin
      o_valid = 1'b1; o_bpt = 32'd64;
      wait_desc(ok);
      checks++;
      if (!ok || m_od_addr !== 32'h1000 * (p + 1) || m_od_len !== 32'd64 || m_od_tag !== 8'(p)) begin
        errors++;
        $display("FAIL ring_desc%0d: got ok=%b addr=%h len=%0d tag=%0d expected addr=%h len=64 tag=%0d", p, ok, m_od_addr, m_od_len, m_od_tag, 32'h1000 * (p + 1), p);
      end
      finish_beat();
    end
    o_valid = 1'b1; o_bpt = 32'd64;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_od_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL ring_stall: descriptor issued while bank 0 busy, expected stall"); end
    reg_wr(9, 32'd1);
    wait_desc(ok);
    checks++;
    if (!ok || m_od_addr !== 32'h1000 || m_od_tag !== 8'd0) begin
      errors++;
      $display("FAIL ring_wrap: got ok=%b addr=%h tag=%0d expected addr=1000 tag=0", ok, m_od_addr, m_od_tag);
    end
    finish_beat();
    reg_rd(4, d); checks++;
    if (d !== 32'h0000_0400) begin errors++; $display("FAIL ring_status: got %h expected 00000400", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, a0, l0;
    logic [7:0]  t0;
    bit ok, bad;
    start_ring();
    m_od_ready = 1'b0;
    o_valid = 1'b1; o_bpt = 32'd128;
    wait_desc(ok);
    a0 = m_od_addr; l0 = m_od_len; t0 = m_od_tag;
    checks++;
    if (!ok || a0 !== 32'h1000 || l0 !== 32'd128 || t0 !== 8'd0) begin
      errors++;
      $display("FAIL bp_desc: got ok=%b addr=%h len=%0d tag=%0d expected 1000/128/0", ok, a0, l0, t0);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      reg_rd(4, d);
      if (!m_od_valid || m_od_addr !== a0 || m_od_len !== l0 || m_od_tag !== t0 || d[15:8] !== 8'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL bp_hold: got valid=%b addr=%h outstanding=%0d expected held fields and outstanding 0", m_od_valid, m_od_addr, d[15:8]); end
    m_od_ready = 1'b1;
    tick();
    checks++;
    if (m_od_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b expected 0", m_od_valid); end
    reg_rd(4, d); checks++;
    if (d[15:8] !== 8'd1) begin errors++; $display("FAIL bp_outstanding: got %0d expected 1", d[15:8]); end
    finish_beat();
  endtask

  task automatic test_priority();
    logic [31:0] d;
    os_valid = 1'b1; os_tag = 8'd1; os_error = 4'd0;
    reg_wr(14, 32'd0);
    os_valid = 1'b0;
    reg_rd(14, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL prio_done_write1: got %h expected 1", d); end
    complete(0, 0);
    reg_rd(4, d); checks++;
    if (d[15:8] !== 8'd0) begin errors++; $display("FAIL prio_outstanding_floor: got %0d expected 0", d[15:8]); end
  endtask

  task automatic test_error();
    logic [31:0] d, exp_err;
    exp_err = CAP ? 32'h8000_0204 : 32'd0;
    start_ring();
    complete(2, 4);
    reg_rd(3, d); checks++;
    if (d !== exp_err) begin errors++; $display("FAIL err_capture: got %h expected %h", d, exp_err); end
    reg_rd(18, d); checks++;
    if (d !== (CAP ? 32'd0 : 32'd1)) begin errors++; $display("FAIL err_done_write2: got %h expected %0d", d, !CAP); end
    complete(3, 0);
    reg_rd(22, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL err_oor_tag: got %h expected 0", d); end
    reg_rd(3, d); checks++;
    if (d !== exp_err) begin errors++; $display("FAIL err_sticky: got %h expected %h", d, exp_err); end
    start_ring();
    reg_rd(3, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL err_start_clear: got %h expected 0", d); end
  endtask

  task automatic test_odone();
    logic [31:0] d;
    bit ok;
    start_ring();
    o_valid = 1'b1; o_bpt = 32'd32;
    wait_desc(ok);
    finish_beat();
    tick();
    reg_rd(2, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL odone_busy: got %h expected 0", d); end
    complete(0, 0);
    tick(); tick();
    reg_rd(2, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL odone_set: got %h expected 1", d); end
    o_valid = 1'b1; o_bpt = 32'd16;
    tick();
    reg_rd(2, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL odone_clear: got %h expected 0", d); end
    finish_beat();
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    bit ok;
    m_od_ready = 1'b0;
    start_ring();
    o_valid = 1'b1; o_bpt = 32'd256;
    wait_desc(ok);
    rst = 1'b1;
    #1;
    checks++;
    if (m_od_valid !== 1'b0 || m_od_addr !== 32'd0 || m_od_len !== 32'd0 || m_od_tag !== 8'd0) begin
      errors++;
      $display("FAIL rst_drop: got valid=%b addr=%h len=%h tag=%h expected all zero", m_od_valid, m_od_addr, m_od_len, m_od_tag);
    end
    o_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    reg_rd(1, d); checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL rst_n_active: got %h expected 2", d); end
    m_od_ready = 1'b1;
    o_valid = 1'b1; o_bpt = 32'd8;
    wait_desc(ok);
    checks++;
    if (!ok || m_od_tag !== 8'd0 || m_od_addr !== 32'd0 || m_od_len !== 32'd8) begin
      errors++;
      $display("FAIL rst_first_bank: got ok=%b addr=%h len=%0d tag=%0d expected 0/8/0", ok, m_od_addr, m_od_len, m_od_tag);
    end
    finish_beat();
  endtask

  // Reference: bank k of each epoch is k mod N_ACTIVE, addressed by BASE[bank].
  task automatic test_random();
    logic [31:0] d, base [NB];
    int n, idx, bpt, dly, err;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(2, NB);
      reg_wr(1, 32'(n));
      for (int b = 0; b < NB; b++) begin
        base[b] = $urandom & 32'hFFFF_FF00;
        reg_wr(8 + 4 * b, base[b]);
      end
      start_ring();
      idx = 0;
      for (int p = 0; p < 8; p++) begin
        bpt = $urandom_range(1, 4096);
        dly = $urandom_range(0, 3);
        m_od_ready = (dly == 0);
        o_valid = 1'b1; o_bpt = 32'(bpt);
        wait_desc(ok);
        checks++;
        if (!ok || m_od_addr !== base[idx] || m_od_len !== 32'(bpt) || m_od_tag !== 8'(idx)) begin
          errors++;
          $display("FAIL rand_desc r%0d p%0d: got ok=%b addr=%h len=%0d tag=%0d expected addr=%h len=%0d tag=%0d", r, p, ok, m_od_addr, m_od_len, m_od_tag, base[idx], bpt, idx);
        end
        finish_beat();
        for (int k = 0; k < dly; k++) tick();
        m_od_ready = 1'b1;
        tick();
        reg_rd(4, d); checks++;
        if (d !== {16'd0, 8'd1, 8'(idx)}) begin errors++; $display("FAIL rand_status_busy r%0d p%0d: got %h expected outstanding 1 idx %0d", r, p, d, idx); end
        err = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
        complete(idx, err);
        reg_rd(10 + 4 * idx, d); checks++;
        if (d !== 32'((err == 0) || !CAP)) begin errors++; $display("FAIL rand_done_write r%0d p%0d: got %h expected %0d", r, p, d, (err == 0) || !CAP); end
        reg_rd(11 + 4 * idx, d); checks++;
        if (d !== 32'(bpt)) begin errors++; $display("FAIL rand_bytes r%0d p%0d: got %0d expected %0d", r, p, d, bpt); end
        reg_rd(9 + 4 * idx, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rand_done_read r%0d p%0d: got %h expected 0", r, p, d); end
        reg_rd(4, d); checks++;
        if (d !== {16'd0, 8'd0, 8'(idx)}) begin errors++; $display("FAIL rand_status_idle r%0d p%0d: got %h expected outstanding 0 idx %0d", r, p, d, idx); end
        reg_wr(9 + 4 * idx, 32'd1);
        idx = (idx + 1) % n;
      end
    end
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_ring();
    test_backpressure();
    test_priority();
    test_error();
    test_odone();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
